riscv_sig_dump: RTL
===================

# riscv_sig_dump

Hardware signature-dump controller for RISC-V architecture-test runs on the tinybiriscv SoC.
- Watches core data-bus writes for a `tohost` completion write, with a timeout fallback.
- On completion or timeout, reads a parametrised signature window from the 64-bit program/data memory and streams it out as 32-bit words, low half first, with a valid/ready handshake.
- Replaces fixed-delay signature dumping.
- Sits beside the core bus monitor tap and the memory's spare read port.
- Synthesizable, so the same block serves simulation and FPGA runs.

## Interface
Parameters
- MEM_AW, 16: memory word-address width (64-bit words).
- SIG_BASE, 1024: first memory word index of the signature window.
- SIG_WORDS, 18: number of 64-bit words in the window; legal range 1..2^MEM_AW. Output length is 2*SIG_WORDS beats.
- TOHOST_ADDR, 32'h0000_1000: byte address whose nonzero write ends the test.
- TIMEOUT, 20000: cycles in RUN before forced dump; must be ≥ 1.

Ports
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  arm pulse; accepted only in IDLE or DONE.
- mon_we  in  1  core data-bus write strobe (monitor only).
- mon_addr  in  32  core data-bus byte address.
- mon_wdata  in  32  core data-bus write data.
- mem_re  out  1  memory read enable.
- mem_raddr  out  MEM_AW  memory word address.
- mem_rdata  in  64  read data, valid one cycle after mem_re.
- sig_valid  out  1  output beat valid.
- sig_data  out  32  output beat.
- sig_last  out  1  final beat marker, qualified by sig_valid.
- sig_ready  in  1  consumer accept.
- busy  out  1  state is RUN or any dump state.
- done  out  1  sticky completion flag.
- pass  out  1  captured tohost value == 1; valid when done = 1.
- timeout  out  1  dump was forced by timeout; valid when done = 1.
- tohost_val  out  32  captured tohost write data; 0 on timeout.

## Operation
States: IDLE, RUN, RD, CAP, LO, HI, DONE.

- **IDLE → RUN** on start. The timeout counter (width $clog2(TIMEOUT+1)) clears.
- **RUN**
  - Counter increments every cycle.
  - On mon_we && mon_addr == TOHOST_ADDR && mon_wdata != 0: tohost_val ← mon_wdata, word index ← 0, go to RD.
  - A tohost write with zero data is ignored.
  - Else, when counter == TIMEOUT−1: timeout ← 1, go to RD.
  - If the trigger and timeout fall in the same cycle, the trigger wins and timeout stays 0.
- **RD**: mem_re = 1 and mem_raddr = (SIG_BASE + idx) mod 2^MEM_AW for exactly one cycle; go to CAP.
- **CAP**: buffer ← mem_rdata; go to LO.
- **LO**: sig_valid = 1, sig_data = buffer[31:0]. On sig_ready, go to HI.
- **HI**: sig_data = buffer[63:32]; sig_last = (idx == SIG_WORDS−1). On sig_ready:
  - if last, go to DONE;
  - else idx += 1 and go to RD.
- **DONE**: done = 1 and pass = (tohost_val == 1); both hold. start returns to RUN and clears done, pass, timeout and tohost_val.
- start is ignored in RUN and in all dump states.
- Bus monitor inputs are ignored outside RUN.

## Timing
- **Reset values**: state IDLE; all outputs 0, including mem_raddr, sig_data, tohost_val and the counter.
  - rst has priority over every other input.
  - rst mid-run or mid-dump aborts immediately; no partial-beat completion.
- **Trigger latency**: a trigger sampled at edge k gives mem_re high in cycle k..k+1. The first sig_valid is high after edge k+2.
- **Handshake**
  - A beat transfers on the edge where sig_valid && sig_ready.
  - sig_data and sig_last are stable while sig_valid = 1 and sig_ready = 0.
  - sig_valid never drops without a transfer.
- **Throughput**: 4 cycles per 64-bit word with sig_ready tied high. A full dump takes 4*SIG_WORDS cycles, plus 1 to reach DONE.
- **Timeout**: with no trigger, RD is entered exactly TIMEOUT cycles after the start edge.
- **Address wrap**: SIG_BASE + idx wraps modulo 2^MEM_AW without error.

## Test plan
- **Pass path**: start, then 50 cycles later a write of 0x1 to TOHOST_ADDR, with memory words 1024..1041 preloaded with distinct patterns, sig_ready = 1. Expect 36 beats in low/high order, sig_last only on beat 36, then done = 1, pass = 1, timeout = 0, tohost_val = 1.
- **Fail code**: tohost write of 0x7, preceded by a write of 0x0 to the same address. Expect the zero write ignored, the dump to occur, pass = 0 and tohost_val = 7.
- **Timeout**: TIMEOUT = 100 with no tohost write. Expect mem_re high exactly 100 cycles after start, the dump to complete, timeout = 1, pass = 0.
- **Backpressure**: sig_ready random at 30% duty. Expect the beat sequence identical to the pass case and data stable during stalls.
- **Collisions**: trigger on the counter's last cycle, expecting timeout = 0. rst asserted mid-dump at beat 10, expecting all outputs 0 next cycle; then restart to a full clean dump.
- **Edge params**: SIG_WORDS = 1, and SIG_BASE = 2^MEM_AW − 1 with SIG_WORDS = 2. Expect 2 beats with sig_last on the second, and address wrap to word 0 respectively.

Source files
------------

// File: rtl/riscv_sig_dump.sv
// Signature-dump controller: waits for a tohost write or timeout, then
// streams a 64-bit memory window out as 32-bit beats, low half first.
module riscv_sig_dump #(
  parameter int          MEM_AW      = 16,
  parameter int          SIG_BASE    = 1024,
  parameter int          SIG_WORDS   = 18,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          TIMEOUT     = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mon_we,
  input  logic [31:0]       mon_addr,
  input  logic [31:0]       mon_wdata,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [63:0]       mem_rdata,
  output logic              sig_valid,
  output logic [31:0]       sig_data,
  output logic              sig_last,
  input  logic              sig_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       tohost_val
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [MEM_AW-1:0] IDX_LAST = MEM_AW'(SIG_WORDS - 1);
  localparam logic [MEM_AW-1:0] BASE = MEM_AW'(SIG_BASE);

  typedef enum logic [2:0] {
    IDLE, RUN, RD, CAP, LO, HI, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [MEM_AW-1:0] idx;
  logic [63:0]       buffer;
  logic [31:0]       tohost_q;
  logic              timeout_q;

  logic trig;
  logic expire;
  logic is_last;

  assign trig = (state == RUN) && mon_we
             && (mon_addr == TOHOST_ADDR)
             && (mon_wdata != 32'd0);
  assign expire = (state == RUN) && (cnt == CNT_LAST);
  assign is_last = (idx == IDX_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (trig || expire) state_nx = RD;
      RD:         state_nx = CAP;
      CAP:        state_nx = LO;
      LO:         if (sig_ready) state_nx = HI;
      HI: begin
        if (sig_ready) state_nx = is_last ? DONE : RD;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      buffer    <= '0;
      tohost_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt       <= '0;
            idx       <= '0;
            tohost_q  <= '0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // Trigger outranks a coincident timeout
          if (trig) begin
            tohost_q <= mon_wdata;
            idx      <= '0;
          end else if (expire) begin
            timeout_q <= 1'b1;
            idx       <= '0;
          end
        end
        CAP: buffer <= mem_rdata;
        HI: begin
          if (sig_ready && !is_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_re    = (state == RD);
  assign mem_raddr = mem_re ? BASE + idx : '0;
  assign sig_valid = (state == LO) || (state == HI);
  assign sig_data  = (state == LO) ? buffer[31:0]
                   : (state == HI) ? buffer[63:32]
                   : 32'd0;
  assign sig_last  = (state == HI) && is_last;

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign pass       = done && (tohost_q == 32'd1);
  assign timeout    = timeout_q;
  assign tohost_val = tohost_q;

endmodule
